// File: rtl/avmm_chan_regs_if.sv
// Avalon-MM slave bus bundle for avmm_chan_regs: fixed-latency reads, byte-enabled writes.
// No waitrequest; every transfer is accepted in the cycle it is presented.
interface avmm_chan_regs_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, write, writedata, byteenable, read,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, write, writedata, byteenable, read,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/avmm_chan_regs.sv
// Avalon-MM register bank driving NUM_CH output channels, with immediate or
// shadowed (atomic commit) update of the active values and a 16-bit commit counter.
module avmm_chan_regs #(
    parameter int                NUM_CH  = 4,
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    avmm_chan_regs_if.slave          bus,
    output logic [NUM_CH*DATA_W-1:0] R,
    output logic                     update
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_CH + 1);

    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [DATA_W-1:0] active [NUM_CH];
    logic [DATA_W-1:0] wr_val [NUM_CH];
    logic              mode;
    logic              pending;
    logic [15:0]       count;
    logic [DATA_W-1:0] readdata_q;
    logic              readdatavalid_q;
    logic              update_q;

    logic [NUM_CH-1:0] ch_hit;
    logic              ctrl_hit;
    logic              status_hit;
    logic              ctrl_wr;
    logic              commit;
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        ch_hit     = '0;
        ctrl_hit   = (bus.address == CTRL_ADDR);
        status_hit = (bus.address == STATUS_ADDR);
        rd_mux     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = (bus.address == ADDR_W'(i));
            wr_val[i] = shadow[i];
            for (int b = 0; b < NB; b++) begin
                if (bus.byteenable[b]) begin
                    wr_val[i][b*8 +: 8] = bus.writedata[b*8 +: 8];
                end
            end
            if (ch_hit[i]) begin
                rd_mux = shadow[i];
            end
        end
        if (ctrl_hit) begin
            rd_mux[0] = mode;
        end
        if (status_hit) begin
            rd_mux[15:0]       = count;
            rd_mux[DATA_W-1]   = pending;
        end
        // Leaving shadowed mode with uncommitted writes commits them implicitly.
        ctrl_wr = bus.write && ctrl_hit && bus.byteenable[0];
        commit  = ctrl_wr && (bus.writedata[1] || (mode && !bus.writedata[0] && pending));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= RST_VAL;
                active[i] <= RST_VAL;
            end
            mode            <= 1'b0;
            pending         <= 1'b0;
            count           <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            update_q        <= 1'b0;
        end else begin
            readdatavalid_q <= bus.read;
            readdata_q      <= bus.read ? rd_mux : '0;
            update_q        <= commit;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.write && ch_hit[i]) begin
                    shadow[i] <= wr_val[i];
                    if (!mode) begin
                        active[i] <= wr_val[i];
                    end
                end
                if (commit) begin
                    active[i] <= shadow[i];
                end
            end
            if (bus.write && (|ch_hit) && mode) begin
                pending <= 1'b1;
            end
            if (commit) begin
                pending <= 1'b0;
                count   <= count + 16'd1;
            end
            if (ctrl_wr) begin
                mode <= bus.writedata[0];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign R[g*DATA_W +: DATA_W] = active[g];
    end

    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = readdatavalid_q;
    assign update            = update_q;
endmodule

// File: tb/tb_avmm_chan_regs.sv
// Self-checking bench for avmm_chan_regs: directed literal checks plus randomized
// traffic compared every cycle against a register-level reference model.
module tb_avmm_chan_regs;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam logic [DATA_W-1:0] RST_VAL = '0;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH*DATA_W-1:0] R;
    logic                     update;

    avmm_chan_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avmm_chan_regs #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RST_VAL(RST_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .R(R), .update(update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents as the bus sees them.
    logic [DATA_W-1:0] m_shadow [NUM_CH];
    logic [DATA_W-1:0] m_active [NUM_CH];
    bit                m_mode;
    bit                m_pending;
    int                m_count;
    logic [DATA_W-1:0] exp_rd;
    bit                exp_rdv;
    bit                exp_upd;
    bit                model_live = 0;
    bit                wrap_phase = 0;
    int                upd_seen   = 0;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input int a);
        if (a < NUM_CH)       return m_shadow[a];
        if (a == NUM_CH)      return {31'd0, m_mode};
        if (a == NUM_CH + 1)  return {m_pending, 15'd0, m_count[15:0]};
        return '0;
    endfunction

    always @(posedge clk) begin
        int a;
        bit do_commit;
        logic [DATA_W-1:0] w;
        a = int'(bus.address);
        do_commit = 0;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_shadow[i] = RST_VAL;
                m_active[i] = RST_VAL;
            end
            m_mode = 0; m_pending = 0; m_count = 0;
            exp_rd = '0; exp_rdv = 0;
        end else begin
            exp_rdv = bus.read;
            exp_rd  = bus.read ? model_read(a) : '0;
            if (bus.write && a < NUM_CH) begin
                w = m_shadow[a];
                for (int b = 0; b < DATA_W/8; b++)
                    if (bus.byteenable[b]) w[b*8 +: 8] = bus.writedata[b*8 +: 8];
                m_shadow[a] = w;
                if (m_mode) m_pending = 1;
                else        m_active[a] = w;
            end else if (bus.write && a == NUM_CH && bus.byteenable[0]) begin
                do_commit = bus.writedata[1] || (m_mode && !bus.writedata[0] && m_pending);
                if (do_commit) begin
                    for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
                    m_pending = 0;
                    m_count   = (m_count + 1) % 65536;
                end
                m_mode = bus.writedata[0];
            end
        end
        exp_upd    = do_commit;
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < NUM_CH; i++)
                checkOutput($sformatf("R_ch%0d", i), R[i*DATA_W +: DATA_W], m_active[i]);
            checkOutput("update", {31'd0, update}, {31'd0, exp_upd});
            checkOutput("readdatavalid", {31'd0, bus.readdatavalid}, {31'd0, exp_rdv});
            checkOutput("readdata", bus.readdata, exp_rd);
            if (wrap_phase && update) upd_seen++;
        end
    end

    task automatic applyStimulus(input bit w, input bit r, input int addr,
                                 input logic [DATA_W-1:0] wd, input logic [3:0] be);
        @(negedge clk);
        bus.write      = w;
        bus.read       = r;
        bus.address    = ADDR_W'(addr);
        bus.writedata  = wd;
        bus.byteenable = be;
    endtask

    task automatic settle(output logic [DATA_W-1:0] rd);
        @(negedge clk);
        rd = bus.readdata;
        bus.write = 0; bus.read = 0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;
    endtask

    task automatic doWrite(input int addr, input logic [DATA_W-1:0] wd, input logic [3:0] be);
        logic [DATA_W-1:0] dummy;
        applyStimulus(1, 0, addr, wd, be);
        settle(dummy);
    endtask

    task automatic doRead(input int addr, output logic [DATA_W-1:0] rd);
        applyStimulus(0, 1, addr, '0, '0);
        settle(rd);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] rd;
        int sel;
        logic [DATA_W-1:0] wd;
        logic [3:0] be;

        rst_n = 0;
        bus.write = 0; bus.read = 0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        checkOutput("reset_R", R[DATA_W-1:0], RST_VAL);
        doRead(NUM_CH + 1, rd);
        checkOutput("reset_status", rd, 32'h0000_0000);

        // Immediate mode with partial byte enables.
        doWrite(1, 32'hDEAD_BEEF, 4'b0011);
        checkOutput("imm_R_ch1", R[63:32], 32'h0000_BEEF);
        checkOutput("imm_update", {31'd0, update}, 32'd0);
        doRead(1, rd);
        checkOutput("imm_rd_ch1", rd, 32'h0000_BEEF);

        // Shadowed mode and explicit commit.
        doWrite(NUM_CH, 32'h1, 4'hF);
        doWrite(0, 32'h11, 4'hF);
        doWrite(3, 32'h33, 4'hF);
        checkOutput("shd_R_ch0_held", R[31:0], 32'h0);
        checkOutput("shd_R_ch3_held", R[127:96], 32'h0);
        doRead(NUM_CH + 1, rd);
        checkOutput("shd_status_pending", rd, 32'h8000_0000);
        doWrite(NUM_CH, 32'h3, 4'hF);
        checkOutput("cmt_R_ch0", R[31:0], 32'h11);
        checkOutput("cmt_R_ch3", R[127:96], 32'h33);
        checkOutput("cmt_update", {31'd0, update}, 32'd1);
        doRead(NUM_CH + 1, rd);
        checkOutput("cmt_status", rd, 32'h0000_0001);

        // Implicit commit on leaving shadowed mode, then same-cycle read/write.
        doWrite(2, 32'h22, 4'hF);
        checkOutput("imp_R_ch2_held", R[95:64], 32'h0);
        doWrite(NUM_CH, 32'h0, 4'hF);
        checkOutput("imp_R_ch2", R[95:64], 32'h22);
        checkOutput("imp_update", {31'd0, update}, 32'd1);
        doRead(NUM_CH + 1, rd);
        checkOutput("imp_status", rd, 32'h0000_0002);
        applyStimulus(1, 1, 2, 32'h99, 4'hF);
        settle(rd);
        checkOutput("rw_same_old", rd, 32'h22);
        doRead(2, rd);
        checkOutput("rw_same_new", rd, 32'h99);

        // CTRL write without byte lane 0 is ignored.
        doWrite(NUM_CH, 32'h3, 4'b1110);
        doRead(NUM_CH + 1, rd);
        checkOutput("ctrl_be0_ignored", rd, 32'h0000_0002);

        // Reset mid-sequence with pending writes and a read in flight.
        doWrite(NUM_CH, 32'h1, 4'hF);
        doWrite(0, 32'h55, 4'hF);
        applyStimulus(0, 1, 0, '0, '0);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        bus.read = 0;
        checkOutput("rst_rdv", {31'd0, bus.readdatavalid}, 32'd0);
        checkOutput("rst_update", {31'd0, update}, 32'd0);
        checkOutput("rst_R_ch0", R[31:0], RST_VAL);
        doRead(NUM_CH, rd);
        checkOutput("rst_mode", rd, 32'h0);
        doWrite(NUM_CH + 5, 32'hFFFF_FFFF, 4'hF);
        doRead(NUM_CH + 5, rd);
        checkOutput("unmapped_rd", rd, 32'h0);
        doRead(NUM_CH + 1, rd);
        checkOutput("unmapped_status", rd, 32'h0);

        // Randomized traffic, including occasional resets.
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            be  = 4'($urandom);
            if (sel < NUM_CH) begin
                wd = $urandom;
            end else if (sel == NUM_CH) begin
                wd = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) be[0] = 1'b1;
            end else if (sel == NUM_CH + 1) begin
                wd = $urandom;
            end else begin
                sel = $urandom_range(0, 255);
                wd  = $urandom;
            end
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel, wd, be);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        settle(rd);
        rst_n = 1;

        // Commit counter wraps back to zero after 65536 commits.
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        wrap_phase = 1;
        for (int n = 0; n < 65536; n++) applyStimulus(1, 0, NUM_CH, 32'h2, 4'hF);
        settle(rd);
        doRead(NUM_CH + 1, rd);
        wrap_phase = 0;
        checkOutput("wrap_status", rd, 32'h0000_0000);
        checkOutput("wrap_pulses", upd_seen, 32'd65536);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
